// File: rtl/parking_gate_controller.sv
// Entry/exit gate sequencer: round-robin arbitration between the two gates and the lot occupancy count.
// Optional PARK_STATS_EN adds a saturating total_entries counter output.
module parking_gate_controller #(
  parameter int CAPACITY    = 7,
  parameter int CNT_W       = 3,
  parameter int GATE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_passed,
  output logic             entry_gate,
  output logic             exit_gate,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty
`ifdef PARK_STATS_EN
  ,
  output logic [7:0]       total_entries
`endif
);

  // state      | meaning
  // IDLE       | both gates closed, arbitrating eligible requests
  // ENTRY_OPEN | entry gate open, waiting for car_passed or timeout
  // EXIT_OPEN  | exit gate open, waiting for car_passed or timeout
  // CLOSE      | both gates closed for one cycle, requests ignored

  localparam int TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {IDLE, ENTRY_OPEN, EXIT_OPEN, CLOSE} state_t;
  typedef enum logic {SRV_ENTRY, SRV_EXIT} side_t;

  state_t           state_q, state_d;
  side_t            last_q, last_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] occupancy_q, occupancy_d;
  logic             entry_gate_q, entry_gate_d;
  logic             exit_gate_q, exit_gate_d;
  logic             entry_ok, exit_ok;
`ifdef PARK_STATS_EN
  logic [7:0]       total_entries_q, total_entries_d;
`endif

  assign full     = (occupancy_q == CAP);
  assign empty    = (occupancy_q == '0);
  assign entry_ok = entry_req & ~full;
  assign exit_ok  = exit_req & ~empty;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    timer_d      = '0;
    occupancy_d  = occupancy_q;
    entry_gate_d = 1'b0;
    exit_gate_d  = 1'b0;
`ifdef PARK_STATS_EN
    total_entries_d = total_entries_q;
`endif
    case (state_q)
      IDLE: begin
        // entry wins a tie unless it was the side served last
        if (entry_ok && (!exit_ok || last_q == SRV_EXIT)) begin
          state_d      = ENTRY_OPEN;
          last_d       = SRV_ENTRY;
          entry_gate_d = 1'b1;
        end else if (exit_ok) begin
          state_d     = EXIT_OPEN;
          last_d      = SRV_EXIT;
          exit_gate_d = 1'b1;
        end
      end
      ENTRY_OPEN: begin
        if (car_passed) begin
          state_d = CLOSE;
          if (occupancy_q != CAP) occupancy_d = occupancy_q + 1'b1;
`ifdef PARK_STATS_EN
          if (total_entries_q != 8'hFF) total_entries_d = total_entries_q + 8'd1;
`endif
        end else if (timer_q == TMR_LAST) begin
          state_d = CLOSE;
        end else begin
          timer_d      = timer_q + 1'b1;
          entry_gate_d = 1'b1;
        end
      end
      EXIT_OPEN: begin
        if (car_passed) begin
          state_d = CLOSE;
          if (occupancy_q != '0) occupancy_d = occupancy_q - 1'b1;
        end else if (timer_q == TMR_LAST) begin
          state_d = CLOSE;
        end else begin
          timer_d     = timer_q + 1'b1;
          exit_gate_d = 1'b1;
        end
      end
      CLOSE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_q       <= SRV_EXIT;
      timer_q      <= '0;
      occupancy_q  <= '0;
      entry_gate_q <= 1'b0;
      exit_gate_q  <= 1'b0;
`ifdef PARK_STATS_EN
      total_entries_q <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      timer_q      <= timer_d;
      occupancy_q  <= occupancy_d;
      entry_gate_q <= entry_gate_d;
      exit_gate_q  <= exit_gate_d;
`ifdef PARK_STATS_EN
      total_entries_q <= total_entries_d;
`endif
    end
  end

  assign entry_gate = entry_gate_q;
  assign exit_gate  = exit_gate_q;
  assign occupancy  = occupancy_q;
`ifdef PARK_STATS_EN
  assign total_entries = total_entries_q;
`endif

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench for parking_gate_controller: per-cycle expected gate/occupancy tuples are
// queued as stimulus is driven and compared after each rising edge.
module tb_parking_gate_controller;
  localparam int CAPACITY    = 7;
  localparam int CNT_W       = 3;
  localparam int GATE_CYCLES = 4;

  logic             clk, clk_en, rst_n;
  logic             entry_req, exit_req, car_passed;
  logic             entry_gate, exit_gate, full, empty;
  logic [CNT_W-1:0] occupancy;
`ifdef PARK_STATS_EN
  logic [7:0]       total_entries;
`endif

  int         errors = 0;
  int         checks = 0;
  bit         both_open_seen = 0;
  logic [6:0] exp_q[$];
  wire  [6:0] obs = {entry_gate, exit_gate, occupancy, full, empty};

  parking_gate_controller #(
    .CAPACITY(CAPACITY), .CNT_W(CNT_W), .GATE_CYCLES(GATE_CYCLES)
  ) dut (
    .clk(clk), .reset(rst_n),
    .entry_req(entry_req), .exit_req(exit_req), .car_passed(car_passed),
    .entry_gate(entry_gate), .exit_gate(exit_gate),
    .occupancy(occupancy), .full(full), .empty(empty)
`ifdef PARK_STATS_EN
    , .total_entries(total_entries)
`endif
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(negedge clk) if (entry_gate && exit_gate) both_open_seen = 1'b1;

  function automatic logic [6:0] pack_exp(input logic eg, input logic xg, input int occ);
    return {eg, xg, 3'(occ), occ == CAPACITY, occ == 0};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quick_entry();
    exit_req = 1'b0; entry_req = 1'b1;
    cycle();
    entry_req = 1'b0; car_passed = 1'b1;
    cycle();
    car_passed = 1'b0;
    cycle();
  endtask

  task automatic quick_exit();
    entry_req = 1'b0; exit_req = 1'b1;
    cycle();
    exit_req = 1'b0; car_passed = 1'b1;
    cycle();
    car_passed = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    logic [6:0] e;
    @(negedge clk);
    clk_en = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.push_back(pack_exp(0, 0, 0));
    #3;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_clock_stopped: got %b expected %b", obs, e);
    end
    #2 rst_n = 1'b1;
    #2 clk_en = 1'b1;
  endtask

  task automatic test_single_entry();
    logic [4:0] stim [5] = '{5'b100_10, 5'b000_10, 5'b001_00, 5'b000_00, 5'b001_00};
    int         occs [5] = '{0, 0, 1, 1, 1};
    logic [6:0] e;
    for (int i = 0; i < 5; i++) begin
      {entry_req, exit_req, car_passed} = stim[i][4:2];
      exp_q.push_back(pack_exp(stim[i][1], stim[i][0], occs[i]));
      cycle();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single_entry[%0d]: got %b expected %b", i, obs, e);
      end
    end
    car_passed = 1'b0;
  endtask

  task automatic test_timeout();
    // second window: car_passed on the timeout edge still counts
    logic [4:0] stim [13] = '{5'b100_10, 5'b000_10, 5'b000_10, 5'b000_10, 5'b000_00,
                              5'b001_00, 5'b000_00,
                              5'b100_10, 5'b000_10, 5'b000_10, 5'b000_10, 5'b001_00,
                              5'b000_00};
    int         occs [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2};
    logic [6:0] e;
    for (int i = 0; i < 13; i++) begin
      {entry_req, exit_req, car_passed} = stim[i][4:2];
      exp_q.push_back(pack_exp(stim[i][1], stim[i][0], occs[i]));
      cycle();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout[%0d]: got %b expected %b", i, obs, e);
      end
    end
    car_passed = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [4:0] stim [12] = '{5'b110_10, 5'b111_00, 5'b110_00,
                              5'b110_01, 5'b111_00, 5'b110_00,
                              5'b110_10, 5'b111_00, 5'b110_00,
                              5'b110_01, 5'b111_00, 5'b110_00};
    int         occs [12] = '{3, 4, 4, 4, 3, 3, 3, 4, 4, 4, 3, 3};
    logic [6:0] e;
    for (int i = 0; i < 12; i++) begin
      {entry_req, exit_req, car_passed} = stim[i][4:2];
      exp_q.push_back(pack_exp(stim[i][1], stim[i][0], occs[i]));
      cycle();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL arbitration[%0d]: got %b expected %b", i, obs, e);
      end
    end
    {entry_req, exit_req, car_passed} = 3'b000;
  endtask

  task automatic test_bounds();
    logic [4:0] stim_hi [6] = '{5'b100_00, 5'b100_00, 5'b100_00, 5'b110_01, 5'b111_00, 5'b000_00};
    int         occs_hi [6] = '{7, 7, 7, 7, 6, 6};
    logic [6:0] e;
    for (int i = 0; i < 4; i++) quick_entry();
    for (int i = 0; i < 6; i++) begin
      {entry_req, exit_req, car_passed} = stim_hi[i][4:2];
      exp_q.push_back(pack_exp(stim_hi[i][1], stim_hi[i][0], occs_hi[i]));
      cycle();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL bounds_full[%0d]: got %b expected %b", i, obs, e);
      end
    end
    for (int i = 0; i < 6; i++) quick_exit();
    for (int i = 0; i < 4; i++) begin
      {entry_req, exit_req, car_passed} = 3'b010;
      exp_q.push_back(pack_exp(0, 0, 0));
      cycle();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL bounds_empty[%0d]: got %b expected %b", i, obs, e);
      end
    end
    exit_req = 1'b0;
  endtask

  task automatic test_reset_mid_open();
    logic [6:0] e;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    quick_entry();
    quick_entry();
`ifdef PARK_STATS_EN
    checks++;
    if (total_entries !== 8'd2) begin
      errors++;
      $display("FAIL stats_count: got %0d expected 2", total_entries);
    end
`endif
    entry_req = 1'b1;
    exp_q.push_back(pack_exp(1, 0, 2));
    cycle();
    entry_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL mid_open_gate: got %b expected %b", obs, e);
    end
    #2 rst_n = 1'b0;
    exp_q.push_back(pack_exp(0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL mid_open_reset: got %b expected %b", obs, e);
    end
`ifdef PARK_STATS_EN
    checks++;
    if (total_entries !== 8'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d expected 0", total_entries);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] e;
    clk_en = 1'b1; rst_n = 1'b0;
    entry_req = 1'b0; exit_req = 1'b0; car_passed = 1'b0;
    exp_q.push_back(pack_exp(0, 0, 0));
    #12;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_initial: got %b expected %b", obs, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    quick_entry();
    test_reset();
    test_single_entry();
    test_timeout();
    quick_entry();
    quick_entry();
    quick_exit();
    test_arbitration();
    test_bounds();
    test_reset_mid_open();
    checks++;
    if (both_open_seen !== 1'b0) begin
      errors++;
      $display("FAIL gates_exclusive: got both open %0d expected 0", both_open_seen);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
